// File: rtl/dcntr_sched.sv
`default_nettype none
// ============================================================================
// Module      : dcntr_sched
// Description : Four-requester round-robin scheduler that owns one shared
//               down-counter. The winner loads its own value, counts down
//               to zero and then gets a one-cycle done pulse.
//               Optional macro DCNTR_SCHED_ABORT_EN: the owner dropping its
//               request during the countdown aborts the countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module dcntr_sched #(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] req_val,
  output logic [3:0]         gnt,
  output logic [CNT_W-1:0]   cnt,
  output logic               busy,
  output logic [3:0]         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [3:0]         done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         owner_q, owner_d;

  logic [CNT_W-1:0]   val_arr [4];
  logic [1:0]         win_idx;
  logic               win_found;
  logic [1:0]         cand;
  logic               owner_drop;

  // Split the packed load-value bus into one entry per requester.
  for (genvar k = 0; k < 4; k++) begin : g_slice
    assign val_arr[k] = req_val[k*CNT_W +: CNT_W];
  end

  // Owner releasing its request only matters when aborting is enabled.
`ifdef DCNTR_SCHED_ABORT_EN
  assign owner_drop = ~req[owner_q];
`else
  assign owner_drop = 1'b0;
`endif

  // Round-robin pick: scan starting one past the last granted index.
  always_comb begin
    win_idx   = last_q;
    win_found = 1'b0;
    cand      = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = 4'b0000;
        if (win_found) begin
          state_d = S_COUNT;
          owner_d = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          cnt_d   = val_arr[win_idx];
        end
      end
      S_COUNT: begin
        if (owner_drop) begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
          last_d  = owner_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 4'b0001 << owner_q;
          last_d  = owner_q;
        end
      end
      S_DONE: begin
        // Always return through IDLE so grants are one cycle apart.
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dcntr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcntr_sched
// Description : Self-checking bench for dcntr_sched: vector table, directed
//               corner sequences and randomized traffic against a model.
//               Honours DCNTR_SCHED_ABORT_EN when predicting results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcntr_sched;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         req = 4'b0000;
  logic [4*CNT_W-1:0] req_val = '0;
  logic [3:0]         gnt;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [3:0]         done;

  int errors = 0;
  int checks = 0;

  dcntr_sched #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .req_val(req_val),
    .gnt    (gnt),
    .cnt    (cnt),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {gnt, cnt, busy, done}.
  function automatic int outs();
    return int'({gnt, cnt, busy, done});
  endfunction

  function automatic int pack(input int g, input int c, input int b, input int d);
    return (g << 9) | (c << 5) | (b << 4) | d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, then sample just after the edge.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [15:0] v);
    @(negedge clk);
    reset   = r;
    req     = rq;
    req_val = v;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction-level view) ----------------
  int m_own  = -1;  // current owner, -1 when nobody holds the counter
  int m_cnt  = 0;
  int m_last = 3;
  bit m_fin  = 1'b0; // owner is in its completion cycle

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [15:0] v);
    bit drop;
    bit found;
    int k;
    drop = 1'b0;
    if (r) begin
      m_own = -1; m_cnt = 0; m_last = 3; m_fin = 1'b0;
    end else if (m_fin) begin
      m_own = -1; m_fin = 1'b0;
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        k = (m_last + i) % 4;
        if (!found && rq[k]) begin
          found = 1'b1;
          m_own = k;
          m_cnt = (int'(v) >> (4 * k)) & 15;
        end
      end
    end else begin
`ifdef DCNTR_SCHED_ABORT_EN
      drop = !rq[m_own];
`endif
      if (drop) begin
        m_last = m_own; m_own = -1; m_cnt = 0;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_fin = 1'b1; m_last = m_own;
      end
    end
  endtask

  function automatic int model_out();
    int g;
    g = (m_own >= 0) ? (1 << m_own) : 0;
    return pack(g, m_cnt, (m_own >= 0) ? 1 : 0, m_fin ? g : 0);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [15:0] v;
    int          g;
    int          c;
    int          b;
    int          d;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int grants [$];
    int gaps [$];
    int prev_g;
    int idle_run;
    int dcount;
    logic [3:0] rq_r;

    tbl[0]  = '{1'b1, 4'b0000, 16'h0000, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 4'b0000, 16'h0000, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 4'b0001, 16'h0003, 1, 3, 1, 0};
    tbl[3]  = '{1'b0, 4'b0001, 16'h0007, 1, 2, 1, 0};
    tbl[4]  = '{1'b0, 4'b0001, 16'h0007, 1, 1, 1, 0};
    tbl[5]  = '{1'b0, 4'b0001, 16'h0007, 1, 0, 1, 0};
    tbl[6]  = '{1'b0, 4'b0001, 16'h0007, 1, 0, 1, 1};
    tbl[7]  = '{1'b0, 4'b0001, 16'h0003, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 4'b0010, 16'h0000, 2, 0, 1, 0};
    tbl[9]  = '{1'b0, 4'b0010, 16'h0000, 2, 0, 1, 2};
    tbl[10] = '{1'b0, 4'b0000, 16'h0000, 0, 0, 0, 0};

    // Reset held from time 0 for two full periods.
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].rq, tbl[i].v);
      chk($sformatf("vec%0d", i), outs(), pack(tbl[i].g, tbl[i].c, tbl[i].b, tbl[i].d));
    end

    // Round-robin with all requesters active, value 1 each.
    cycle(1'b1, 4'b0000, 16'h0000);
    prev_g = 0;
    idle_run = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 4'b1111, 16'h1111);
      if (gnt != 4'b0000 && prev_g == 0) begin
        grants.push_back(int'(gnt));
        gaps.push_back(idle_run);
      end
      if (gnt == 4'b0000) idle_run++;
      else idle_run = 0;
      prev_g = int'(gnt);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) begin
        chk($sformatf("rr_grant%0d", i), grants[i], 1 << (i % 4));
        if (i > 0) chk($sformatf("rr_gap%0d", i), gaps[i], 1);
      end else begin
        chk($sformatf("rr_missing%0d", i), -1, 1 << (i % 4));
      end
    end

    // Owner 0 with value 9 drops its request once cnt reaches 5.
    cycle(1'b1, 4'b0000, 16'h0000);
    cycle(1'b0, 4'b0001, 16'h0009);
    chk("abort_grant", outs(), pack(1, 9, 1, 0));
    for (int i = 0; i < 20 && cnt != 4'd5; i++) cycle(1'b0, 4'b0001, 16'h0009);
    chk("abort_reach5", int'(cnt), 5);
    cycle(1'b0, 4'b0000, 16'h0009);
`ifdef DCNTR_SCHED_ABORT_EN
    chk("abort_idle", outs(), 0);
    cycle(1'b0, 4'b0000, 16'h0009);
    chk("abort_stay_idle", outs(), 0);
`else
    chk("noabort_continue", outs(), pack(1, 4, 1, 0));
    dcount = 0;
    for (int i = 0; i < 10 && done == 4'b0000; i++) cycle(1'b0, 4'b0000, 16'h0009);
    chk("noabort_done", outs(), pack(1, 0, 1, 1));
    cycle(1'b0, 4'b0000, 16'h0009);
    chk("noabort_done_single", int'(done), 0);
`endif

    // Asynchronous reset in the middle of a countdown.
    cycle(1'b1, 4'b0000, 16'h0000);
    cycle(1'b0, 4'b0001, 16'h0006);
    cycle(1'b0, 4'b0001, 16'h0006);
    cycle(1'b0, 4'b0001, 16'h0006);
    chk("rst_mid_cnt4", int'(cnt), 4);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", outs(), 0);
    cycle(1'b1, 4'b0000, 16'h0000);
    chk("rst_no_done", outs(), 0);
    cycle(1'b0, 4'b0011, 16'h0025);
    chk("rst_prio0", outs(), pack(1, 5, 1, 0));

    // Randomized traffic against the model.
    cycle(1'b1, 4'b0000, 16'h0000);
    model_step(1'b1, 4'b0000, 16'h0000);
    rq_r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic [15:0] v;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq_r[b] = ~rq_r[b];
      r = ($urandom_range(0, 99) == 0);
      v = 16'($urandom) & 16'h7777;
      cycle(r, rq_r, v);
      model_step(r, rq_r, v);
      chk($sformatf("rand%0d", i), outs(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dcntr_sched.md
DCNTR_SCHED -- requirements
Module: dcntr_sched

Interface
REQ-001 Parameter: CNT_W, default 4, width of the shared down-counter and of each load value.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  per-requester request for a countdown; bit k belongs to requester k.
REQ-005 Port: req_val  input  4*CNT_W  load values; slice [k*CNT_W +: CNT_W] belongs to requester k.
REQ-006 Port: gnt  output  4  one-hot grant; owner of the shared counter; all-zero when no owner.
REQ-007 Port: cnt  output  CNT_W  current shared counter value.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  4  one-hot, single-cycle completion pulse to the owner.

Function
REQ-010 FSM has exactly three states: IDLE, COUNT, DONE; all outputs are registered.
REQ-011 IDLE, req nonzero: on the next edge, select winner k by round-robin, set gnt to one-hot k, load cnt from slice k of req_val, and enter COUNT.
REQ-012 IDLE, req zero: hold state, gnt=0, done=0, cnt unchanged.
REQ-013 Round-robin: search order starts at (last+1) mod 4, where last is the last granted index; last updates on entry to DONE.
REQ-014 req_val is sampled only at grant; later changes are ignored.
REQ-015 COUNT, cnt nonzero: decrement cnt by 1 per edge; no wrap-around occurs.
REQ-016 COUNT, cnt==0: on the next edge enter DONE and set done[k]=1; cnt stays 0.
REQ-017 DONE: on the next edge clear gnt and done and enter IDLE; no grant is issued in the same edge.
REQ-018 Timing for load value V: gnt high for V+2 cycles (V+1 in COUNT, 1 in DONE); done high for exactly 1 cycle.
REQ-019 A load value of 0 gives 1 COUNT cycle followed by DONE.
REQ-020 Back-to-back grants are separated by exactly one IDLE cycle.
REQ-021 Requests from non-owners during COUNT or DONE are held pending and do not disturb the owner.
REQ-022 Owner deassertion of req during COUNT follows the Configuration section.

Reset
REQ-023 While reset is high, regardless of clk: state=IDLE, gnt=0, done=0, busy=0, cnt=0, last=3.
REQ-024 Because last resets to 3, requester 0 has first priority after reset.
REQ-025 Reset asserted mid-COUNT or in DONE aborts the operation immediately; no done pulse is issued.

Configuration
REQ-026 Macro DCNTR_SCHED_ABORT_EN selects abort behaviour.
REQ-027 With DCNTR_SCHED_ABORT_EN defined: if req[k] of the owner is low at an edge in COUNT, the next state is IDLE with gnt=0, done=0, cnt=0, and last=k.
REQ-028 Without DCNTR_SCHED_ABORT_EN: owner req deassertion is ignored and the countdown completes with a done pulse.

Verification
REQ-029 Reset high 20 ns, then low -> gnt=0000, cnt=0, busy=0, done=0000.
REQ-030 req=0001, slice0=3 -> gnt=0001; cnt sequence 3,2,1,0; done=0001 for 1 cycle; gnt high for 5 cycles.
REQ-031 req=1111 held, all slices=1 -> grants issued in order 0001, 0010, 0100, 1000, 0001, each pair separated by one idle cycle.
REQ-032 req=0010, slice1=0 -> one COUNT cycle with cnt=0, then done=0010.
REQ-033 Owner 0 with value 9 drops req at cnt=5 -> with the macro: IDLE next edge, no done; without the macro: done=0001 after cnt reaches 0.
REQ-034 Reset pulsed while cnt=4 -> immediate IDLE, cnt=0, no done; req=0001 afterwards is granted to requester 0.
